sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port SDRAM controller (we/rd/ready/wtbt/addr/din/dout interface), clocked on clk_p.
- Master 0 is the CPU bus; master 1 is a DMA requester (disk controller / loader).
- Converts each master's strobe/ack bus cycle into one controller transaction, selects masters round-robin, and returns registered read data with a one-cycle ack.
- Replaces the ad-hoc ack-delay logic at board level.

Parameters:
ADDR_W, 21, master word address is adr[ADDR_W:1]
TIMEOUT, 255, max clk_p cycles spent waiting on the controller before a transaction is aborted; 8-bit counter

Ports:
clk_p  in  1  system clock, 100 MHz forward phase
rst_n  in  1  asynchronous active-low reset
init_done  in  1  SDRAM controller finished initialisation (sdram_ready)
m0_stb  in  1  master 0 request, held until m0_ack
m0_we  in  1  master 0 write (1) / read (0)
m0_sel  in  2  master 0 byte lanes; bit1 = high byte, bit0 = low byte
m0_adr  in  ADDR_W  master 0 word address
m0_dat_i  in  16  master 0 write data
m0_dat_o  out  16  master 0 read data
m0_ack  out  1  master 0 completion pulse
m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i, m1_dat_o, m1_ack: identical set for master 1
ctl_rd  out  1  controller read request
ctl_we  out  1  controller write request
ctl_wtbt  out  2  controller byte-write mask (= latched sel)
ctl_addr  out  25  controller byte address {zero pad, adr, 1'b0}
ctl_din  out  16  controller write data
ctl_dout  in  16  controller read data
ctl_ready  in  1  controller idle / data valid
grant  out  1  master currently or last served
timeout_err  out  1  one-cycle pulse on an aborted transaction

Behaviour:
- Reset: all outputs 0; state IDLE; last-served pointer = 1, so master 0 wins the first tie; timeout counter 0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Acts only if init_done=1 and at least one stb=1.
  - Winner: the sole requester; on a tie, the master not last served.
  - Latch we, sel, adr, dat_i of the winner; set grant. Next state ISSUE.
  - stb with init_done=0 is held pending with no ack.
- ISSUE:
  - Assert ctl_rd (latched we=0) or ctl_we (we=1) as a level.
  - ctl_addr, ctl_din, ctl_wtbt come from latched registers and stay stable for the whole transaction.
  - When ctl_ready=0 (request accepted): drop ctl_rd/ctl_we and go to WAIT.
- WAIT:
  - On ctl_ready=1: for a read, capture ctl_dout into the granted master's dat_o; go to ACK.
  - The other master's dat_o is unchanged.
- ACK:
  - Granted master's ack=1 for exactly this one cycle. Update the last-served pointer; go to IDLE.
  - A master drops stb the cycle after it sees ack, so no duplicate transaction can start.
- Timeout:
  - The counter clears on entry to ISSUE and counts in ISSUE and WAIT.
  - Reaching TIMEOUT: drop requests, set dat_o=16'hFFFF for a read, pulse timeout_err, go to ACK. The master still receives ack.
- dat_o holds its value until that master's next read completion. Writes never alter dat_o.
- Master-side changes after latching (including stb dropping early) are ignored until ACK.
- Latency: stb sampled in cycle N → ISSUE in N+1 → ack in cycle (ready-rise cycle + 1). Minimum 4 cycles with an ideal controller.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight transaction is abandoned and no ack is issued.
- sel=2'b00 is passed through unchanged; the controller interprets it.

Test Plan:
1. After reset, init_done=0 and m0_stb=1 read adr=0x00010 → no ctl_rd and no ack for 20 cycles; raise init_done → ctl_rd=1, ctl_addr=0x000020. Controller model drops ready 1 cycle later and raises it 5 cycles later with dout=0x1234 → m0_dat_o=0x1234, m0_ack one cycle.
2. m1 write adr=0x1FFFFF, dat=0xA55A, sel=2'b10 → ctl_we=1, ctl_addr=0x3FFFFE, ctl_wtbt=2'b10, ctl_din=0xA55A; m1_ack once; m0_dat_o and m1_dat_o unchanged.
3. Both stb asserted continuously for 6 transactions each → grants alternate 0,1,0,1…; acks never overlap; each transaction sees exactly one ctl_rd/ctl_we assertion.
4. Controller holds ready=1 forever during ISSUE, TIMEOUT=255 → after 255 cycles timeout_err pulses, m0_dat_o=0xFFFF, m0_ack=1; the next request proceeds normally.
5. rst_n pulsed low during WAIT → all outputs 0 asynchronously; no ack; after release a fresh m0 read completes correctly with master 0 winning the first tie.
6. Back-to-back m0 reads at consecutive addresses, stb dropped on ack and re-raised next cycle → two distinct ctl_rd transactions, correct data for each, no spurious third ack.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the SDRAM controller.
// The arbiter uses the slave view; the masters/controller side uses master.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              init_done;
  logic              m0_stb;
  logic              m0_we;
  logic [1:0]        m0_sel;
  logic [ADDR_W-1:0] m0_adr;
  logic [15:0]       m0_dat_i;
  logic [15:0]       m0_dat_o;
  logic              m0_ack;
  logic              m1_stb;
  logic              m1_we;
  logic [1:0]        m1_sel;
  logic [ADDR_W-1:0] m1_adr;
  logic [15:0]       m1_dat_i;
  logic [15:0]       m1_dat_o;
  logic              m1_ack;
  logic              ctl_rd;
  logic              ctl_we;
  logic [1:0]        ctl_wtbt;
  logic [24:0]       ctl_addr;
  logic [15:0]       ctl_din;
  logic [15:0]       ctl_dout;
  logic              ctl_ready;
  logic              grant;
  logic              timeout_err;

  modport slave (
    input  init_done,
    input  m0_stb, m0_we, m0_sel, m0_adr, m0_dat_i,
    output m0_dat_o, m0_ack,
    input  m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i,
    output m1_dat_o, m1_ack,
    output ctl_rd, ctl_we, ctl_wtbt, ctl_addr, ctl_din,
    input  ctl_dout, ctl_ready,
    output grant, timeout_err
  );

  modport master (
    output init_done,
    output m0_stb, m0_we, m0_sel, m0_adr, m0_dat_i,
    input  m0_dat_o, m0_ack,
    output m1_stb, m1_we, m1_sel, m1_adr, m1_dat_i,
    input  m1_dat_o, m1_ack,
    input  ctl_rd, ctl_we, ctl_wtbt, ctl_addr, ctl_din,
    output ctl_dout, ctl_ready,
    input  grant, timeout_err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin two-master arbiter/sequencer in front of the SDRAM controller.
// One controller transaction per strobe, registered read data, 1-cycle ack.
module sdram_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 255
) (
  input logic            clk_p,
  input logic            rst_n,
  sdram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_grant;
  logic              r_we;
  logic              r_to;
  logic [1:0]        r_sel;
  logic [ADDR_W-1:0] r_adr;
  logic [15:0]       r_din;
  logic [15:0]       r_dat0;
  logic [15:0]       r_dat1;
  logic [7:0]        r_cnt;

  logic              w_start;
  logic              w_win;
  logic              w_busy;
  logic              w_done;
  logic              w_abort;
  logic [15:0]       w_rdata;

  assign w_start = (r_state == S_IDLE) & bus.init_done
                 & (bus.m0_stb | bus.m1_stb);
  // On a tie the master not served last wins
  assign w_win   = (bus.m0_stb & bus.m1_stb) ? ~r_last : bus.m1_stb;
  assign w_busy  = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign w_done  = (r_state == S_WAIT) & bus.ctl_ready;
  assign w_abort = w_busy & (r_cnt == LIMIT) & ~w_done;
  assign w_rdata = w_done ? bus.ctl_dout : 16'hFFFF;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_abort)             w_next = S_ACK;
        else if (!bus.ctl_ready) w_next = S_WAIT;
      end
      S_WAIT:  if (w_done | w_abort) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_we    <= 1'b0;
      r_to    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_din   <= '0;
      r_dat0  <= '0;
      r_dat1  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_to    <= w_abort;
      if (w_start) begin
        r_grant <= w_win;
        r_we    <= w_win ? bus.m1_we    : bus.m0_we;
        r_sel   <= w_win ? bus.m1_sel   : bus.m0_sel;
        r_adr   <= w_win ? bus.m1_adr   : bus.m0_adr;
        r_din   <= w_win ? bus.m1_dat_i : bus.m0_dat_i;
        r_cnt   <= '0;
      end else if (w_busy) begin
        r_cnt   <= r_cnt + 8'd1;
      end
      if ((w_done | w_abort) & ~r_we) begin
        if (r_grant) r_dat1 <= w_rdata;
        else         r_dat0 <= w_rdata;
      end
      if (r_state == S_ACK) r_last <= r_grant;
    end
  end

  assign bus.ctl_rd      = (r_state == S_ISSUE) & ~r_we;
  assign bus.ctl_we      = (r_state == S_ISSUE) & r_we;
  assign bus.ctl_wtbt    = r_sel;
  assign bus.ctl_addr    = 25'({r_adr, 1'b0});
  assign bus.ctl_din     = r_din;
  assign bus.m0_dat_o    = r_dat0;
  assign bus.m1_dat_o    = r_dat1;
  assign bus.m0_ack      = (r_state == S_ACK) & ~r_grant;
  assign bus.m1_ack      = (r_state == S_ACK) & r_grant;
  assign bus.grant       = r_grant;
  assign bus.timeout_err = r_to;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller with a word memory,
// two master drivers and a request log used as the expected-order reference.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(21)) bus();

  sdram_arbiter #(
    .ADDR_W(21),
    .TIMEOUT(255)
  ) dut (
    .clk_p(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    bit          gnt;
    bit          we;
    logic [24:0] addr;
    logic [1:0]  wtbt;
    logic [15:0] din;
  } log_t;

  int n_checks = 0;
  int n_fail = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int ovl_cnt = 0;
  int to_cnt = 0;
  int rd_hi = 0;
  int req_rise = 0;

  logic [15:0] mem [int unsigned];
  log_t clog[$];
  bit stuck = 0;
  bit rand_lat = 0;
  int lat = 1;
  logic [15:0] exp0 = '0;
  logic [15:0] exp1 = '0;

  bit          rq_we  [2][6];
  logic [1:0]  rq_sel [2][6];
  logic [20:0] rq_adr [2][6];
  logic [15:0] rq_din [2][6];

  function automatic logic [15:0] mem_rd(int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 16'(a * 32'd40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [80:0] outs();
    return {bus.ctl_rd, bus.ctl_we, bus.ctl_wtbt, bus.ctl_addr,
            bus.ctl_din, bus.m0_dat_o, bus.m1_dat_o, bus.m0_ack,
            bus.m1_ack, bus.grant, bus.timeout_err};
  endfunction

  // Controller: ready idles high, drops when it takes a request,
  // rises again with data after a latency.
  initial begin : ctl_model
    bit busy;
    int cnt;
    int unsigned k;
    logic [15:0] old;
    log_t e;
    busy = 0;
    cnt = 0;
    k = 0;
    bus.ctl_ready = 1'b1;
    bus.ctl_dout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
        bus.ctl_ready = 1'b1;
      end else if (busy) begin
        if (cnt == 0) begin
          busy = 0;
          bus.ctl_ready = 1'b1;
          bus.ctl_dout = mem_rd(k);
        end else begin
          cnt--;
        end
      end else if (!stuck && (bus.ctl_rd || bus.ctl_we)) begin
        k = 32'(bus.ctl_addr[24:1]);
        e.gnt = bus.grant;
        e.we = bus.ctl_we;
        e.addr = bus.ctl_addr;
        e.wtbt = bus.ctl_wtbt;
        e.din = bus.ctl_din;
        clog.push_back(e);
        if (bus.ctl_we) begin
          old = mem_rd(k);
          mem[k] = {e.wtbt[1] ? e.din[15:8] : old[15:8],
                    e.wtbt[0] ? e.din[7:0] : old[7:0]};
        end
        busy = 1;
        cnt = rand_lat ? int'($urandom_range(0, 5)) : lat;
        bus.ctl_ready = 1'b0;
      end
    end
  end

  initial begin : mon
    bit prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (bus.m0_ack) ack0_cnt++;
      if (bus.m1_ack) ack1_cnt++;
      if (bus.m0_ack && bus.m1_ack) ovl_cnt++;
      if (bus.timeout_err) to_cnt++;
      if (bus.ctl_rd) rd_hi++;
      if ((bus.ctl_rd || bus.ctl_we) && !prev) req_rise++;
      prev = bus.ctl_rd || bus.ctl_we;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  task automatic do_txn(input bit m, input bit we,
                        input logic [1:0] sel,
                        input logic [20:0] adr,
                        input logic [15:0] d,
                        output logic [15:0] got,
                        output bit to, output bit ok);
    @(negedge clk);
    if (!m) begin
      bus.m0_we = we; bus.m0_sel = sel;
      bus.m0_adr = adr; bus.m0_dat_i = d;
      bus.m0_stb = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_sel = sel;
      bus.m1_adr = adr; bus.m1_dat_i = d;
      bus.m1_stb = 1'b1;
    end
    ok = 0;
    to = 0;
    got = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m ? bus.m1_ack : bus.m0_ack) begin
        got = m ? bus.m1_dat_o : bus.m0_dat_o;
        to = bus.timeout_err;
        ok = 1;
        break;
      end
    end
    if (!m) bus.m0_stb = 1'b0;
    else    bus.m1_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.init_done = 1'b0;
    bus.m0_stb = 0; bus.m0_we = 0; bus.m0_sel = 0;
    bus.m0_adr = 0; bus.m0_dat_i = 0;
    bus.m1_stb = 0; bus.m1_we = 0; bus.m1_sel = 0;
    bus.m1_adr = 0; bus.m1_dat_i = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs() !== 81'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== 81'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", outs());
    end
  endtask

  task automatic test_init_gate();
    int a0, r0;
    bit seen;
    mem[32'h10] = 16'h1234;
    lat = 4;
    rand_lat = 0;
    @(negedge clk);
    bus.m0_we = 0; bus.m0_sel = 2'b11;
    bus.m0_adr = 21'h10; bus.m0_dat_i = 0;
    bus.m0_stb = 1'b1;
    a0 = ack0_cnt;
    r0 = rd_hi;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rd_hi != r0 || ack0_cnt != a0) begin
      n_fail++;
      $display("FAIL init_gate: rd cycles %0d acks %0d expected 0 0",
               rd_hi - r0, ack0_cnt - a0);
    end
    bus.init_done = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ctl_rd) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || bus.ctl_addr !== 25'h20) begin
      n_fail++;
      $display("FAIL init_addr: seen %0b addr %h expected 1 000020",
               seen, bus.ctl_addr);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m0_ack) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || bus.m0_dat_o !== 16'h1234) begin
      n_fail++;
      $display("FAIL init_read: ack %0b data %h expected 1 1234",
               seen, bus.m0_dat_o);
    end
    exp0 = 16'h1234;
    bus.m0_stb = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ack0_cnt - a0 != 1) begin
      n_fail++;
      $display("FAIL init_single_ack: got %0d expected 1",
               ack0_cnt - a0);
    end
  endtask

  task automatic test_write();
    int base, a1;
    logic [15:0] got;
    bit to, ok;
    log_t e;
    lat = 2;
    base = clog.size();
    a1 = ack1_cnt;
    do_txn(1, 1, 2'b10, 21'h1FFFFF, 16'hA55A, got, to, ok);
    n_checks++;
    if (!ok || clog.size() != base + 1) begin
      n_fail++;
      $display("FAIL wr_done: ack %0b reqs %0d expected 1 1",
               ok, clog.size() - base);
    end else begin
      e = clog[base];
      n_checks++;
      if ({e.gnt, e.we, e.addr, e.wtbt, e.din} !==
          {1'b1, 1'b1, 25'h3FFFFE, 2'b10, 16'hA55A}) begin
        n_fail++;
        $display("FAIL wr_fields: got g%0b w%0b %h %b %h expected g1 w1 3ffffe 10 a55a",
                 e.gnt, e.we, e.addr, e.wtbt, e.din);
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.m0_dat_o, bus.m1_dat_o} !== {exp0, exp1}) begin
      n_fail++;
      $display("FAIL wr_dat_kept: got %h %h expected %h %h",
               bus.m0_dat_o, bus.m1_dat_o, exp0, exp1);
    end
    n_checks++;
    if (ack1_cnt - a1 != 1) begin
      n_fail++;
      $display("FAIL wr_single_ack: got %0d expected 1", ack1_cnt - a1);
    end
  endtask

  task automatic drv(input bit m);
    logic [15:0] got, ex;
    bit to, ok;
    for (int i = 0; i < 6; i++) begin
      rq_we[m][i]  = 1'($urandom_range(0, 1));
      rq_sel[m][i] = 2'($urandom_range(0, 3));
      rq_adr[m][i] = {m, 20'($urandom)};
      rq_din[m][i] = 16'($urandom);
      ex = mem_rd(32'(rq_adr[m][i]));
      do_txn(m, rq_we[m][i], rq_sel[m][i], rq_adr[m][i],
             rq_din[m][i], got, to, ok);
      n_checks++;
      if (!ok || (!rq_we[m][i] && got !== ex)) begin
        n_fail++;
        $display("FAIL rr_txn m%0d #%0d: ack %0b data %h expected 1 %h",
                 m, i, ok, got, ex);
      end
      if (!rq_we[m][i]) begin
        if (m) exp1 = ex;
        else   exp0 = ex;
      end
    end
  endtask

  task automatic test_round_robin();
    int base, r0;
    log_t e;
    bit m;
    int j;
    rand_lat = 1;
    base = clog.size();
    r0 = req_rise;
    fork
      drv(1'b0);
      drv(1'b1);
    join
    rand_lat = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (clog.size() - base != 12 || req_rise - r0 != 12) begin
      n_fail++;
      $display("FAIL rr_count: reqs %0d rises %0d expected 12 12",
               clog.size() - base, req_rise - r0);
    end
    n_checks++;
    if (ovl_cnt != 0) begin
      n_fail++;
      $display("FAIL rr_no_overlap: got %0d expected 0", ovl_cnt);
    end
    for (int k = 0; k < 12 && base + k < clog.size(); k++) begin
      e = clog[base + k];
      m = k[0];
      j = k / 2;
      n_checks++;
      if ({e.gnt, e.we, e.addr, e.wtbt, e.din} !==
          {m, rq_we[m][j], 25'({rq_adr[m][j], 1'b0}),
           rq_sel[m][j], rq_din[m][j]}) begin
        n_fail++;
        $display("FAIL rr_order #%0d: got g%0b w%0b %h expected g%0b w%0b %h",
                 k, e.gnt, e.we, e.addr, m, rq_we[m][j],
                 25'({rq_adr[m][j], 1'b0}));
      end
    end
  endtask

  task automatic test_timeout();
    int r0, t0;
    logic [15:0] got, ex;
    bit to, ok;
    stuck = 1;
    r0 = rd_hi;
    t0 = to_cnt;
    do_txn(0, 0, 2'b11, 21'h00ABC, 16'h0, got, to, ok);
    n_checks++;
    if (!ok || to !== 1'b1 || got !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL to_abort: ack %0b err %0b data %h expected 1 1 ffff",
               ok, to, got);
    end
    n_checks++;
    if (rd_hi - r0 != 255) begin
      n_fail++;
      $display("FAIL to_cycles: got %0d expected 255", rd_hi - r0);
    end
    stuck = 0;
    @(negedge clk);
    n_checks++;
    if (to_cnt - t0 != 1) begin
      n_fail++;
      $display("FAIL to_pulse: got %0d expected 1", to_cnt - t0);
    end
    exp0 = 16'hFFFF;
    lat = 2;
    ex = mem_rd(32'h123);
    do_txn(0, 0, 2'b11, 21'h123, 16'h0, got, to, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok || to || got !== ex || to_cnt - t0 != 1) begin
      n_fail++;
      $display("FAIL to_recover: ack %0b err %0b data %h expected 1 0 %h",
               ok, to, got, ex);
    end
    exp0 = ex;
  endtask

  task automatic test_reset_mid();
    int a0, a1, base;
    bit s1, s2;
    logic [15:0] g0, g1, x0, x1;
    bit t0, t1, k0, k1;
    lat = 20;
    @(negedge clk);
    bus.m0_we = 0; bus.m0_sel = 2'b11;
    bus.m0_adr = 21'h500; bus.m0_stb = 1'b1;
    s1 = 0;
    s2 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ctl_rd) begin s1 = 1; break; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.ctl_rd) begin s2 = 1; break; end
    end
    n_checks++;
    if (!(s1 && s2)) begin
      n_fail++;
      $display("FAIL mid_reach_wait: got %0b%0b expected 11", s1, s2);
    end
    repeat (2) @(negedge clk);
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 81'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0", outs());
    end
    bus.m0_stb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ack0_cnt != a0 || ack1_cnt != a1) begin
      n_fail++;
      $display("FAIL mid_no_ack: got %0d %0d expected 0 0",
               ack0_cnt - a0, ack1_cnt - a1);
    end
    exp0 = '0;
    exp1 = '0;
    lat = 1;
    base = clog.size();
    x0 = mem_rd(32'h600);
    x1 = mem_rd(32'h10700);
    fork
      do_txn(0, 0, 2'b11, 21'h600, 16'h0, g0, t0, k0);
      do_txn(1, 0, 2'b01, 21'h10700, 16'h0, g1, t1, k1);
    join
    n_checks++;
    if (!k0 || g0 !== x0) begin
      n_fail++;
      $display("FAIL mid_m0_read: ack %0b data %h expected 1 %h",
               k0, g0, x0);
    end
    n_checks++;
    if (!k1 || g1 !== x1) begin
      n_fail++;
      $display("FAIL mid_m1_read: ack %0b data %h expected 1 %h",
               k1, g1, x1);
    end
    n_checks++;
    if (clog.size() <= base || clog[base].gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_first_tie: reqs %0d expected m0 first",
               clog.size() - base);
    end
    exp0 = x0;
    exp1 = x1;
  endtask

  task automatic test_back_to_back();
    int a0, base;
    logic [15:0] g1, g2, e1, e2;
    bit t1, t2, k1, k2;
    lat = 1;
    base = clog.size();
    a0 = ack0_cnt;
    e1 = mem_rd(32'h900);
    e2 = mem_rd(32'h901);
    do_txn(0, 0, 2'b11, 21'h900, 16'h0, g1, t1, k1);
    do_txn(0, 0, 2'b11, 21'h901, 16'h0, g2, t2, k2);
    n_checks++;
    if (!k1 || g1 !== e1) begin
      n_fail++;
      $display("FAIL b2b_first: ack %0b data %h expected 1 %h", k1, g1, e1);
    end
    n_checks++;
    if (!k2 || g2 !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: ack %0b data %h expected 1 %h", k2, g2, e2);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (ack0_cnt - a0 != 2) begin
      n_fail++;
      $display("FAIL b2b_ack_count: got %0d expected 2", ack0_cnt - a0);
    end
    n_checks++;
    if (clog.size() - base != 2 ||
        clog[base].addr !== 25'h1200 ||
        clog[base + 1].addr !== 25'h1202) begin
      n_fail++;
      $display("FAIL b2b_addrs: reqs %0d expected 2 at 001200 001202",
               clog.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
